alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  EX/MEM pipeline stage directly downstream of the MIPS ALU; consumes c, zon, hi, lo with the instruction.
//  Registers one instruction at a time under a valid/ready handshake.
//  Owns the architectural HI/LO registers; resolves beq/bne and the overflow trap.
//  Drives the register-file write and the data-memory request.
// PARAMETERS
//  RESET_PC   32'h0000_0000  value of out_pc after reset
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  in_valid       in   1   ALU result + instruction present
//  in_ready       out  1   stage can accept this cycle
//  in_instr       in   32  instruction word fed to the ALU
//  in_pc          in   32  PC of that instruction
//  in_c           in   32  ALU result c
//  in_zon         in   3   ALU flags: [2] zero, [1] overflow, [0] negative
//  in_hi, in_lo   in   32  ALU hi/lo outputs (mult/multu/div/divu)
//  in_gr2         in   32  rt operand (store data, mthi/mtlo source via gr1 path = in_c unused)
//  in_gr1         in   32  rs operand (mthi/mtlo source)
//  flush          in   1   squash held and incoming instruction
//  out_valid      out  1   registered instruction valid
//  out_ready      in   1   downstream accepts
//  out_pc         out  32  registered PC
//  out_result     out  32  writeback value (c, HI or LO)
//  out_wr_en      out  1   register-file write enable
//  out_wr_addr    out  5   destination register
//  out_mem_rd     out  1   lw request;  out_mem_wr out 1 sw request
//  out_mem_addr   out  32  = c;  out_mem_wdata out 32 = gr2
//  branch_taken   out  1   beq/bne resolved taken;  branch_target out 32
//  ovf_trap       out  1   add/addi/sub overflowed (write suppressed)
//  div_zero       out  1   div/divu with gr2==0 (HI/LO unchanged)
//  hi_q, lo_q     out  32  architectural HI/LO
//  retired        out  CNT_W  count of out_valid&&out_ready handshakes
// BEHAVIOUR
//  Reset: out_valid=0, all out_* / flags=0, out_pc=RESET_PC, hi_q=lo_q=0, retired=0. in_ready=1 after reset.
//  State: EMPTY (out_valid=0) / FULL (out_valid=1). in_ready = !out_valid || out_ready (comb).
//  Accept = in_valid && in_ready && !flush: next cycle FULL with all outputs registered (latency 1).
//  FULL && out_ready && !accept -> EMPTY. FULL && out_ready && accept -> FULL, new payload (no bubble).
//  FULL && !out_ready: all outputs held stable; in_ready=0.
//  flush: next cycle EMPTY regardless; incoming dropped, no HI/LO update; in_ready unaffected.
//  HI/LO update on accept only: mult/multu/div/divu load {in_hi,in_lo}; mthi/mtlo load in_gr1;
//   div/divu with in_gr2==0: HI/LO hold, div_zero=1 with that instruction.
//  mfhi/mflo: out_result = hi_q/lo_q sampled at accept (sees any earlier accepted write).
//  Dest: R-type -> instr[15:11]; addi/addiu/andi/ori/xori/slti/sltiu/lw -> instr[20:16];
//   sw/beq/bne/mult*/div*/mthi/mtlo/unknown -> out_wr_en=0. Dest==0 forces out_wr_en=0.
//  ovf_trap = in_zon[1] for add/addi/sub only; then out_wr_en=0; addu/subu never trap.
//  beq taken iff zon[2]=1; bne taken iff zon[2]=0; others 0.
//  branch_target = in_pc + 4 + (sext(instr[15:0]) << 2), mod 2^32, computed for all I-type.
//  Memory: lw -> out_mem_rd=1, sw -> out_mem_wr=1, addr=in_c; wr_addr for lw = rt, out_result=in_c.
//  All flags/enables are qualified: 0 whenever out_valid=0.
//  retired increments on out_valid&&out_ready&&!flush; wraps at 2^CNT_W.
// STRUCTURE
//  mips_pkg: opcode/funct localparams (incl. mfhi 010000, mthi 010001, mflo 010010, mtlo 010011),
//   zon bit indices ZON_Z=2, ZON_V=1, ZON_N=0, instruction field slice helpers.
//  Sub-module hilo_regs: HI/LO registers, load-enable + mux; stage FSM/pipeline reg in top.
// TESTING
//  add 7FFF_FFFF+1 (zon=010) dest r3 -> ovf_trap=1, out_wr_en=0 one cycle later.
//  mult then mflo r5 back-to-back, hi/lo=0000_0001/0000_0002 -> mflo result 0000_0002, wr r5.
//  beq pc=0x100 imm=0xFFFF zon=100 -> taken, target 0x100; bne same -> not taken.
//  out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0, no HI/LO change.
//  div gr2=0 after HI/LO=AAAA_AAAA/5555_5555 -> div_zero=1, HI/LO unchanged.
//  flush while FULL and in_valid -> out_valid=0 next cycle, retired unchanged; rst mid-stall -> all reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct encodings, ALU flag indices and field helpers
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU zon flag bit positions
    localparam int ZON_Z = 2;
    localparam int ZON_V = 1;
    localparam int ZON_N = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] instr);
        return instr[15:0];
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - architectural HI/LO registers with product/quotient or mthi/mtlo load
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_ld_prod        load {i_prod_hi, i_prod_lo} into HI/LO
//   i_ld_hi/i_ld_lo  load i_gr1 into HI or LO (mthi/mtlo)
//   i_prod_hi/lo     ALU hi/lo result
//   i_gr1            rs operand
//   o_hi_q, o_lo_q   register contents
module hilo_regs
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld_prod,
    input  logic        i_ld_hi,
    input  logic        i_ld_lo,
    input  logic [31:0] i_prod_hi,
    input  logic [31:0] i_prod_lo,
    input  logic [31:0] i_gr1,
    output logic [31:0] o_hi_q,
    output logic [31:0] o_lo_q
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else begin
            if (i_ld_prod) begin
                r_hi <= i_prod_hi;
                r_lo <= i_prod_lo;
            end else begin
                if (i_ld_hi) r_hi <= i_gr1;
                if (i_ld_lo) r_lo <= i_gr1;
            end
        end
    end

    assign o_hi_q = r_hi;
    assign o_lo_q = r_lo;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - EX/MEM stage after the MIPS ALU: HI/LO, branch resolve, overflow trap, writeback/memory request
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              upstream handshake (ALU result + instruction)
//   in_instr, in_pc                instruction word and its PC
//   in_c, in_zon, in_hi, in_lo     ALU result, flags {Z,V,N}, hi/lo outputs
//   in_gr1, in_gr2                 rs / rt operands
//   flush                          squash held and incoming instruction
//   out_valid/out_ready            downstream handshake
//   out_pc, out_result             registered PC and writeback value
//   out_wr_en, out_wr_addr         register-file write
//   out_mem_rd/wr/addr/wdata       data-memory request
//   branch_taken, branch_target    beq/bne resolution
//   ovf_trap, div_zero             exception flags
//   hi_q, lo_q                     architectural HI/LO
//   retired                        completed handshake count
module alu_result_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_c,
    input  logic [2:0]       in_zon,
    input  logic [31:0]      in_hi,
    input  logic [31:0]      in_lo,
    input  logic [31:0]      in_gr2,
    input  logic [31:0]      in_gr1,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_result,
    output logic             out_wr_en,
    output logic [4:0]       out_wr_addr,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic [31:0]      out_mem_addr,
    output logic [31:0]      out_mem_wdata,
    output logic             branch_taken,
    output logic [31:0]      branch_target,
    output logic             ovf_trap,
    output logic             div_zero,
    output logic [31:0]      hi_q,
    output logic [31:0]      lo_q,
    output logic [CNT_W-1:0] retired
);

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic             w_accept;

    logic [31:0]      r_pc;
    logic [31:0]      r_result;
    logic             r_wr_en;
    logic [4:0]       r_wr_addr;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_br_taken;
    logic [31:0]      r_br_target;
    logic             r_ovf;
    logic             r_div_zero;
    logic [CNT_W-1:0] r_retired;

    // decode of the incoming instruction
    logic [5:0]       w_op;
    logic [5:0]       w_fn;
    logic             w_rtype;
    logic             w_wr_rd;
    logic             w_wr_rt;
    logic             w_trap_op;
    logic             w_muldiv;
    logic             w_div;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_mfhi;
    logic             w_mflo;
    logic [4:0]       w_dest;
    logic             w_ovf;
    logic             w_div_zero;
    logic             w_br_taken;
    logic [31:0]      w_br_target;
    logic [31:0]      w_result;
    logic [15:0]      w_imm;

    assign w_op    = f_opcode(in_instr);
    assign w_fn    = f_funct(in_instr);
    assign w_rtype = (w_op == OP_RTYPE);
    assign w_imm   = f_imm(in_instr);

    always_comb begin
        w_wr_rd   = 1'b0;
        w_wr_rt   = 1'b0;
        w_trap_op = 1'b0;
        w_muldiv  = 1'b0;
        w_div     = 1'b0;
        w_mthi    = 1'b0;
        w_mtlo    = 1'b0;
        w_mfhi    = 1'b0;
        w_mflo    = 1'b0;
        if (w_rtype) begin
            case (w_fn)
                FN_ADD, FN_SUB: begin
                    w_wr_rd   = 1'b1;
                    w_trap_op = 1'b1;
                end
                FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA,
                FN_SLLV, FN_SRLV, FN_SRAV: w_wr_rd = 1'b1;
                FN_MFHI: begin
                    w_wr_rd = 1'b1;
                    w_mfhi  = 1'b1;
                end
                FN_MFLO: begin
                    w_wr_rd = 1'b1;
                    w_mflo  = 1'b1;
                end
                FN_MULT, FN_MULTU: w_muldiv = 1'b1;
                FN_DIV, FN_DIVU: begin
                    w_muldiv = 1'b1;
                    w_div    = 1'b1;
                end
                FN_MTHI: w_mthi = 1'b1;
                FN_MTLO: w_mtlo = 1'b1;
                default: ;
            endcase
        end else begin
            case (w_op)
                OP_ADDI: begin
                    w_wr_rt   = 1'b1;
                    w_trap_op = 1'b1;
                end
                OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
                OP_LW: w_wr_rt = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_dest      = w_wr_rd ? f_rd(in_instr) : f_rt(in_instr);
    assign w_ovf       = w_trap_op && in_zon[ZON_V];
    assign w_div_zero  = w_div && (in_gr2 == 32'h0);
    assign w_br_taken  = ((w_op == OP_BEQ) &&  in_zon[ZON_Z]) ||
                         ((w_op == OP_BNE) && !in_zon[ZON_Z]);
    assign w_br_target = in_pc + 32'd4 + {{14{w_imm[15]}}, w_imm, 2'b00};
    // mfhi/mflo read the register as it stands now, which already includes
    // any HI/LO write from an instruction accepted on an earlier cycle
    assign w_result    = w_mfhi ? hi_q : (w_mflo ? lo_q : in_c);

    assign in_ready = (r_state == ST_EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = ST_EMPTY;
        else if (w_accept)
            w_state_nxt = ST_FULL;
        else if (out_ready)
            w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_pc        <= RESET_PC;
            r_result    <= 32'h0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_br_taken  <= 1'b0;
            r_br_target <= 32'h0;
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc        <= in_pc;
                r_result    <= w_result;
                r_wr_en     <= (w_wr_rd || w_wr_rt) && (w_dest != 5'd0) && !w_ovf;
                r_wr_addr   <= w_dest;
                r_mem_rd    <= (w_op == OP_LW);
                r_mem_wr    <= (w_op == OP_SW);
                r_mem_addr  <= in_c;
                r_mem_wdata <= in_gr2;
                r_br_taken  <= w_br_taken;
                r_br_target <= w_br_target;
                r_ovf       <= w_ovf;
                r_div_zero  <= w_div_zero;
            end
            if ((r_state == ST_FULL) && out_ready && !flush)
                r_retired <= r_retired + 1'b1;
        end
    end

    hilo_regs u_hilo (
        .clk       (clk),
        .rst       (rst),
        .i_ld_prod (w_accept && w_muldiv && !w_div_zero),
        .i_ld_hi   (w_accept && w_mthi),
        .i_ld_lo   (w_accept && w_mtlo),
        .i_prod_hi (in_hi),
        .i_prod_lo (in_lo),
        .i_gr1     (in_gr1),
        .o_hi_q    (hi_q),
        .o_lo_q    (lo_q)
    );

    logic w_unused;
    assign w_unused = in_zon[ZON_N];

    // enables and flags only mean something while an instruction is held
    assign out_valid     = (r_state == ST_FULL);
    assign out_pc        = r_pc;
    assign out_result    = r_result;
    assign out_wr_en     = r_wr_en    && out_valid;
    assign out_wr_addr   = r_wr_addr;
    assign out_mem_rd    = r_mem_rd   && out_valid;
    assign out_mem_wr    = r_mem_wr   && out_valid;
    assign out_mem_addr  = r_mem_addr;
    assign out_mem_wdata = r_mem_wdata;
    assign branch_taken  = r_br_taken && out_valid;
    assign branch_target = r_br_target;
    assign ovf_trap      = r_ovf      && out_valid;
    assign div_zero      = r_div_zero && out_valid;
    assign retired       = r_retired;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_c;
    logic [2:0]  in_zon;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic [31:0] in_gr2;
    logic [31:0] in_gr1;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_result;
    logic        out_wr_en;
    logic [4:0]  out_wr_addr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic [31:0] out_mem_addr;
    logic [31:0] out_mem_wdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ovf_trap;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_c(in_c), .in_zon(in_zon),
        .in_hi(in_hi), .in_lo(in_lo), .in_gr2(in_gr2), .in_gr1(in_gr1),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ovf_trap(ovf_trap), .div_zero(div_zero),
        .hi_q(hi_q), .lo_q(lo_q), .retired(retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_c = '0;
        in_zon = '0; in_hi = '0; in_lo = '0; in_gr2 = '0; in_gr1 = '0;
        flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_pc",    out_pc,             32'h0);
        check("rst_hi",        hi_q,               32'h0);
        check("rst_lo",        lo_q,               32'h0);
        check("rst_retired",   retired,            32'd0);

        // add r3 = 7FFF_FFFF + 1 overflows
        in_valid = 1'b1; in_pc = 32'h40;
        in_instr = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
        in_c = 32'h8000_0000; in_zon = 3'b010;
        tick();
        check("add_valid",   {31'b0, out_valid}, 32'd1);
        check("add_ovf",     {31'b0, ovf_trap},  32'd1);
        check("add_wr_en",   {31'b0, out_wr_en}, 32'd0);
        check("add_wr_addr", {27'b0, out_wr_addr}, 32'd3);
        check("add_pc",      out_pc,             32'h40);

        // mult then mflo r5 back to back
        in_pc = 32'h44; in_zon = 3'b000; in_c = 32'h0;
        in_instr = {6'b000000, 5'd1, 5'd2, 10'd0, 6'b011000};
        in_hi = 32'h0000_0001; in_lo = 32'h0000_0002;
        tick();
        check("mult_wr_en", {31'b0, out_wr_en}, 32'd0);
        in_pc = 32'h48;
        in_instr = {6'b000000, 10'd0, 5'd5, 5'd0, 6'b010010};
        in_hi = 32'h99; in_lo = 32'h99;
        tick();
        check("mflo_result",  out_result,          32'h0000_0002);
        check("mflo_wr_en",   {31'b0, out_wr_en},  32'd1);
        check("mflo_wr_addr", {27'b0, out_wr_addr}, 32'd5);
        check("mult_hi",      hi_q,                32'h1);
        check("mult_lo",      lo_q,                32'h2);
        in_valid = 1'b0;
        tick();
        check("retired_3",     retired,            32'd3);
        check("empty_valid",   {31'b0, out_valid}, 32'd0);

        // beq taken, target = 0x104 - 4
        in_valid = 1'b1; in_pc = 32'h100; in_zon = 3'b100;
        in_instr = {6'b000100, 5'd1, 5'd2, 16'hFFFF};
        tick();
        check("beq_taken",  {31'b0, branch_taken}, 32'd1);
        check("beq_target", branch_target,         32'h100);
        check("beq_wr_en",  {31'b0, out_wr_en},    32'd0);
        in_instr = {6'b000101, 5'd1, 5'd2, 16'hFFFF};
        tick();
        check("bne_taken",  {31'b0, branch_taken}, 32'd0);
        check("bne_target", branch_target,         32'h100);

        // downstream stall for 3 cycles with a mult waiting
        out_ready = 1'b0; in_pc = 32'h300; in_zon = 3'b000;
        in_instr = {6'b000000, 5'd1, 5'd2, 10'd0, 6'b011000};
        in_hi = 32'hAAAA_AAAA; in_lo = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid",    {31'b0, out_valid}, 32'd1);
            check("stall_in_ready", {31'b0, in_ready},  32'd0);
            check("stall_pc",       out_pc,             32'h100);
            check("stall_hi",       hi_q,               32'h1);
            check("stall_retired",  retired,            32'd4);
        end
        out_ready = 1'b1;
        tick();
        check("rel_pc",      out_pc,  32'h300);
        check("rel_hi",      hi_q,    32'hAAAA_AAAA);
        check("rel_lo",      lo_q,    32'h5555_5555);
        check("rel_retired", retired, 32'd5);

        // div by zero leaves HI/LO alone
        in_pc = 32'h304; in_gr2 = 32'h0; in_hi = 32'h1; in_lo = 32'h1;
        in_instr = {6'b000000, 5'd1, 5'd2, 10'd0, 6'b011010};
        tick();
        check("divz_flag", {31'b0, div_zero}, 32'd1);
        check("divz_hi",   hi_q,              32'hAAAA_AAAA);
        check("divz_lo",   lo_q,              32'h5555_5555);

        // flush while full with an incoming addu
        flush = 1'b1; in_pc = 32'h308;
        in_instr = {6'b000000, 5'd1, 5'd2, 5'd4, 5'd0, 6'b100001};
        tick();
        flush = 1'b0;
        check("flush_valid",   {31'b0, out_valid}, 32'd0);
        check("flush_retired", retired,            32'd6);
        check("flush_divz",    {31'b0, div_zero},  32'd0);

        // lw r7, then stall, then reset mid-stall
        in_pc = 32'h400; in_c = 32'h1000; in_gr2 = 32'h1234;
        in_instr = {6'b100011, 5'd1, 5'd7, 16'h0010};
        tick();
        check("lw_mem_rd",  {31'b0, out_mem_rd},   32'd1);
        check("lw_mem_wr",  {31'b0, out_mem_wr},   32'd0);
        check("lw_wr_addr", {27'b0, out_wr_addr},  32'd7);
        check("lw_wr_en",   {31'b0, out_wr_en},    32'd1);
        check("lw_result",  out_result,            32'h1000);
        check("lw_addr",    out_mem_addr,          32'h1000);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("lw_hold_rd", {31'b0, out_mem_rd},   32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        check("rst2_valid",   {31'b0, out_valid},  32'd0);
        check("rst2_pc",      out_pc,              32'h0);
        check("rst2_hi",      hi_q,                32'h0);
        check("rst2_lo",      lo_q,                32'h0);
        check("rst2_retired", retired,             32'd0);
        check("rst2_mem_rd",  {31'b0, out_mem_rd}, 32'd0);
        check("rst2_in_ready",{31'b0, in_ready},   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
